// File: rtl/cn_u_acc.sv
// Check-node min-sum accumulator: streams one row of v2c messages and reports min/second-min
// magnitudes, the min column, the sign parity and the degree one cycle after the last message.
module cn_u_acc #(
    parameter int MSG_WIDTH   = 6,
    parameter int COL_CNT_WID = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_v2c_vld,
    input  logic [MSG_WIDTH-1:0]   i_v2c,
    input  logic [COL_CNT_WID-1:0] i_col_cnt,
    input  logic                   i_row_start,
    input  logic                   i_row_last,
    output logic                   o_vld,
    output logic [MSG_WIDTH-2:0]   o_v2c_abs_0,
    output logic [MSG_WIDTH-2:0]   o_v2c_abs_1,
    output logic [COL_CNT_WID-1:0] o_idx_0,
    output logic                   o_v2c_sign_tot,
    output logic [COL_CNT_WID-1:0] o_deg,
    output logic                   o_v2c_sign,
    output logic                   o_sign_vld,
    output logic                   o_err
);

    localparam int AW = MSG_WIDTH - 1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          min0_q, min0_d, min1_q, min1_d;
    logic [COL_CNT_WID-1:0] idx_q, idx_d, deg_q, deg_d;
    logic                   signTot_q, signTot_d;
    logic                   err_q, err_d;

    logic                   vld_q, signVld_q, sign_q;
    logic [AW-1:0]          outAbs0_q, outAbs1_q;
    logic [COL_CNT_WID-1:0] outIdx_q, outDeg_q;
    logic                   outSignTot_q;

    logic                   msgSign;
    logic [MSG_WIDTH-1:0]   negV;
    logic [AW-1:0]          msgAbs;
    logic                   accept;

    // The most negative input has no positive twin, so its magnitude saturates to all-ones.
    always_comb begin
        msgSign = i_v2c[MSG_WIDTH-1];
        negV    = -i_v2c;
        msgAbs  = i_v2c[AW-1:0];
        if (msgSign) begin
            if (negV[MSG_WIDTH-1]) begin
                msgAbs = '1;
            end else begin
                msgAbs = negV[AW-1:0];
            end
        end
    end

    assign accept = i_v2c_vld && (i_row_start || (state_q == ACC));

    always_comb begin
        state_d   = state_q;
        min0_d    = min0_q;
        min1_d    = min1_q;
        idx_d     = idx_q;
        deg_d     = deg_q;
        signTot_d = signTot_q;
        err_d     = err_q | (i_v2c_vld && (state_q == IDLE) && !i_row_start);
        if (accept) begin
            if (i_row_start) begin
                min0_d    = msgAbs;
                min1_d    = '1;
                idx_d     = i_col_cnt;
                deg_d     = COL_CNT_WID'(1);
                signTot_d = msgSign;
            end else begin
                // Strict compares keep the earliest column on ties; the duplicate becomes min1.
                if (msgAbs < min0_q) begin
                    min1_d = min0_q;
                    min0_d = msgAbs;
                    idx_d  = i_col_cnt;
                end else if (msgAbs < min1_q) begin
                    min1_d = msgAbs;
                end
                deg_d     = deg_q + COL_CNT_WID'(1);
                signTot_d = signTot_q ^ msgSign;
            end
            if (i_row_last) begin
                state_d = IDLE;
            end else if (i_row_start) begin
                state_d = ACC;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            min0_q       <= '0;
            min1_q       <= '0;
            idx_q        <= '0;
            deg_q        <= '0;
            signTot_q    <= 1'b0;
            err_q        <= 1'b0;
            vld_q        <= 1'b0;
            signVld_q    <= 1'b0;
            sign_q       <= 1'b0;
            outAbs0_q    <= '0;
            outAbs1_q    <= '0;
            outIdx_q     <= '0;
            outDeg_q     <= '0;
            outSignTot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min0_q    <= min0_d;
            min1_q    <= min1_d;
            idx_q     <= idx_d;
            deg_q     <= deg_d;
            signTot_q <= signTot_d;
            err_q     <= err_d;
            signVld_q <= accept;
            vld_q     <= accept && i_row_last;
            if (accept) begin
                sign_q <= msgSign;
            end
            // Row results include the closing message and hold until the next row closes.
            if (accept && i_row_last) begin
                outAbs0_q    <= min0_d;
                outAbs1_q    <= min1_d;
                outIdx_q     <= idx_d;
                outDeg_q     <= deg_d;
                outSignTot_q <= signTot_d;
            end
        end
    end

    assign o_vld          = vld_q;
    assign o_v2c_abs_0    = outAbs0_q;
    assign o_v2c_abs_1    = outAbs1_q;
    assign o_idx_0        = outIdx_q;
    assign o_v2c_sign_tot = outSignTot_q;
    assign o_deg          = outDeg_q;
    assign o_v2c_sign     = sign_q;
    assign o_sign_vld     = signVld_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_cn_u_acc.sv
// Bench for cn_u_acc: directed rows plus random traffic, checked every cycle against a
// row-list reference model that computes results with plain arithmetic over the whole row.
module tb_cn_u_acc;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_v2c_vld;
    logic [5:0] i_v2c;
    logic [3:0] i_col_cnt;
    logic       i_row_start;
    logic       i_row_last;
    logic       o_vld;
    logic [4:0] o_v2c_abs_0;
    logic [4:0] o_v2c_abs_1;
    logic [3:0] o_idx_0;
    logic       o_v2c_sign_tot;
    logic [3:0] o_deg;
    logic       o_v2c_sign;
    logic       o_sign_vld;
    logic       o_err;

    cn_u_acc #(.MSG_WIDTH(6), .COL_CNT_WID(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_v2c_vld(i_v2c_vld), .i_v2c(i_v2c),
        .i_col_cnt(i_col_cnt), .i_row_start(i_row_start), .i_row_last(i_row_last),
        .o_vld(o_vld), .o_v2c_abs_0(o_v2c_abs_0), .o_v2c_abs_1(o_v2c_abs_1),
        .o_idx_0(o_idx_0), .o_v2c_sign_tot(o_v2c_sign_tot), .o_deg(o_deg),
        .o_v2c_sign(o_v2c_sign), .o_sign_vld(o_sign_vld), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {int mag; int col; int sgn;} msg_t;

    msg_t rowQ[$];
    int   checks = 0;
    int   errors = 0;
    int   expVld, expAbs0, expAbs1, expIdx, expSignTot, expDeg, expSign, expSignVld, expErr;
    bit   inRow;

    // Reference state after reset: everything zero, no row open.
    function automatic void modelReset();
        rowQ.delete();
        inRow = 0;
        expVld = 0; expAbs0 = 0; expAbs1 = 0; expIdx = 0; expSignTot = 0;
        expDeg = 0; expSign = 0; expSignVld = 0; expErr = 0;
    endfunction

    // Results from the full list of the row: smallest magnitude (earliest wins), smallest of the rest.
    function automatic void modelCloseRow();
        int m = 0;
        expAbs1 = 31;
        expSignTot = 0;
        for (int i = 1; i < rowQ.size(); i++) if (rowQ[i].mag < rowQ[m].mag) m = i;
        for (int i = 0; i < rowQ.size(); i++) begin
            if (i != m && rowQ[i].mag < expAbs1) expAbs1 = rowQ[i].mag;
            expSignTot = expSignTot ^ rowQ[i].sgn;
        end
        expAbs0 = rowQ[m].mag;
        expIdx  = rowQ[m].col;
        expDeg  = rowQ.size() % 16;
        expVld  = 1;
    endfunction

    function automatic void modelStep(input int vld, input int v, input int col, input int st, input int ls);
        msg_t m;
        bit   acc = (vld != 0) && ((st != 0) || inRow);
        expVld = 0;
        expSignVld = acc;
        if (vld != 0 && !acc) expErr = 1;
        if (acc) begin
            m.mag = (v < 0) ? -v : v;
            if (m.mag > 31) m.mag = 31;
            m.col = col;
            m.sgn = (v < 0) ? 1 : 0;
            expSign = m.sgn;
            if (st != 0) rowQ.delete();
            rowQ.push_back(m);
            if (ls != 0) begin
                modelCloseRow();
                inRow = 0;
            end else begin
                inRow = 1;
            end
        end
    endfunction

    task automatic checkSig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkSig("o_vld", o_vld, expVld);
        checkSig("o_v2c_abs_0", o_v2c_abs_0, expAbs0);
        checkSig("o_v2c_abs_1", o_v2c_abs_1, expAbs1);
        checkSig("o_idx_0", o_idx_0, expIdx);
        checkSig("o_v2c_sign_tot", o_v2c_sign_tot, expSignTot);
        checkSig("o_deg", o_deg, expDeg);
        checkSig("o_v2c_sign", o_v2c_sign, expSign);
        checkSig("o_sign_vld", o_sign_vld, expSignVld);
        checkSig("o_err", o_err, expErr);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next one.
    task automatic applyStimulus(input int vld, input int v, input int col, input int st, input int ls);
        i_v2c_vld   = (vld != 0);
        i_v2c       = 6'(v);
        i_col_cnt   = 4'(col);
        i_row_start = (st != 0);
        i_row_last  = (ls != 0);
        @(posedge i_clk);
        modelStep(vld, v, col, st, ls);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, $urandom_range(0, 63) - 32, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    task automatic checkRow(input string tag, input int a0, input int a1, input int idx, input int st, input int deg);
        checkSig({tag, "_vld"}, o_vld, 1);
        checkSig({tag, "_abs0"}, o_v2c_abs_0, a0);
        checkSig({tag, "_abs1"}, o_v2c_abs_1, a1);
        checkSig({tag, "_idx"}, o_idx_0, idx);
        checkSig({tag, "_signtot"}, o_v2c_sign_tot, st);
        checkSig({tag, "_deg"}, o_deg, deg);
    endtask

    initial begin
        int vldCnt;
        i_rst_n = 1'b0;
        i_v2c_vld = 1'b0; i_v2c = '0; i_col_cnt = '0; i_row_start = 1'b0; i_row_last = 1'b0;
        modelReset();
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        $display("[TB] basic row");
        applyStimulus(1, 5, 0, 1, 0);
        applyStimulus(1, -3, 1, 0, 0);
        applyStimulus(1, 7, 2, 0, 0);
        applyStimulus(1, -3, 3, 0, 1);
        checkRow("basic", 3, 3, 1, 0, 4);
        idle(2);

        $display("[TB] saturation degree-1 row");
        applyStimulus(1, -32, 9, 1, 1);
        checkRow("sat", 31, 31, 9, 1, 1);
        applyStimulus(1, 4, 2, 0, 0);
        checkSig("sat_idle_err", o_err, 1);

        $display("[TB] reset before restart test");
        i_rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        $display("[TB] restart");
        applyStimulus(1, 2, 0, 1, 0);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 6, 0, 1, 0);
        applyStimulus(1, -4, 1, 0, 1);
        checkRow("restart", 4, 6, 1, 1, 2);
        idle(2);

        $display("[TB] back-to-back rows");
        applyStimulus(1, 3, 0, 1, 0);
        applyStimulus(1, 8, 1, 0, 1);
        checkRow("rowA", 3, 8, 0, 0, 2);
        applyStimulus(1, -1, 0, 1, 0);
        checkSig("rowA_pulse_len", o_vld, 0);
        applyStimulus(1, 2, 1, 0, 1);
        checkRow("rowB", 1, 2, 0, 1, 2);
        idle(1);

        $display("[TB] degree wrap");
        for (int i = 0; i < 18; i++) applyStimulus(1, 20 - i, i % 16, (i == 0) ? 1 : 0, (i == 17) ? 1 : 0);
        checkRow("wrap", 3, 4, 1, 0, 2);
        idle(1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 8) ? 1 : 0, $urandom_range(0, 63) - 32,
                          $urandom_range(0, 15), ($urandom_range(0, 9) < 2) ? 1 : 0,
                          ($urandom_range(0, 9) < 2) ? 1 : 0);
        end

        $display("[TB] reset mid-row");
        applyStimulus(1, 5, 0, 1, 0);
        applyStimulus(1, 3, 1, 0, 1);
        applyStimulus(1, 9, 0, 1, 0);
        applyStimulus(1, 7, 1, 0, 0);
        #3;
        i_rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        #2;
        i_rst_n = 1'b1;
        vldCnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 6, 2 + i, 0, (i == 3) ? 1 : 0);
            if (o_vld === 1'b1) vldCnt++;
        end
        checkSig("rst_no_vld", vldCnt, 0);
        applyStimulus(1, -7, 4, 1, 0);
        applyStimulus(1, 6, 5, 0, 1);
        checkRow("post_rst", 6, 7, 5, 1, 2);

        $display("[TB] protocol error");
        i_rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(1, 10, 3, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkSig("err_set", o_err, 1);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, -2, 1, 0, 1);
        checkRow("err_row", 1, 2, 0, 1, 2);
        checkSig("err_sticky", o_err, 1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
